// File: rtl/cmd_arbiter.sv
// rtl/cmd_arbiter.sv - round-robin command arbiter issuing one-cycle command pulses followed by an idle gap
module cmd_arbiter #(
    parameter int         NUM_REQ    = 3,
    parameter int         GAP_CYCLES = 4,
    parameter logic [3:0] IDLE_CODE  = 4'hF,
    localparam int        IDW        = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   reqValid,
    input  logic [4*NUM_REQ-1:0] reqCode,
    output logic [NUM_REQ-1:0]   reqReady,
    output logic [3:0]           outCode,
    output logic                 outValid,
    output logic [IDW-1:0]       grantId,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // The gap counter is preloaded while in ISSUE so it counts GAP_CYCLES-1 .. 0 inside GAP.
    localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t         state_q;
    state_t         state_d;
    logic [IDW-1:0] ptr_q;
    logic [7:0]     gap_q;

    logic           found_hi;
    logic           found_lo;
    logic [IDW-1:0] win_hi;
    logic [IDW-1:0] win_lo;
    logic           found;
    logic [IDW-1:0] win;
    logic [3:0]     win_code;

    logic [3:0]     out_code_d;
    logic           out_valid_d;
    logic [IDW-1:0] grant_d;
    logic           busy_d;

    // Round-robin search: lowest valid index above ptr wins, otherwise wrap to lowest valid index at or below ptr.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        win_code = IDLE_CODE;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (reqValid[j] && (j > int'(ptr_q))) begin
                found_hi = 1'b1;
                win_hi   = IDW'(j);
            end
            if (reqValid[j] && (j <= int'(ptr_q))) begin
                found_lo = 1'b1;
                win_lo   = IDW'(j);
            end
        end
        found = found_hi | found_lo;
        win   = found_hi ? win_hi : win_lo;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (win == IDW'(j)) begin
                win_code = reqCode[4*j +: 4];
            end
        end
    end

    // State, pointer, gap counter and registered outputs; reset discards any command in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= IDW'(NUM_REQ - 1);
            gap_q    <= 8'd0;
            outCode  <= IDLE_CODE;
            outValid <= 1'b0;
            grantId  <= '0;
            busy     <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_IDLE) && found) begin
                ptr_q <= win;
            end
            if (state_q == S_ISSUE) begin
                gap_q <= GAP_LOAD;
            end else if ((state_q == S_GAP) && (gap_q != 8'd0)) begin
                gap_q <= gap_q - 8'd1;
            end
            outCode  <= out_code_d;
            outValid <= out_valid_d;
            grantId  <= grant_d;
            busy     <= busy_d;
        end
    end

    // Next state: an accepted idle code is dropped, so only real commands leave IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (found && (win_code != IDLE_CODE)) state_d = S_ISSUE;
            S_ISSUE: state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
            S_GAP:   if (gap_q == 8'd0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: combinational one-hot ready in IDLE, and next values of the registered command outputs.
    always_comb begin
        for (int j = 0; j < NUM_REQ; j++) begin
            reqReady[j] = !reset && (state_q == S_IDLE) && found && (win == IDW'(j));
        end
        out_code_d  = IDLE_CODE;
        out_valid_d = 1'b0;
        grant_d     = grantId;
        busy_d      = (state_d != S_IDLE);
        if (state_d == S_ISSUE) begin
            out_code_d  = win_code;
            out_valid_d = 1'b1;
            grant_d     = win;
        end
    end

endmodule

// File: tb/tb_cmd_arbiter.sv
// tb/tb_cmd_arbiter.sv - randomized scoreboard bench for cmd_arbiter
module tb_cmd_arbiter;

    localparam int N = 3;

    typedef struct {
        int cyc;
        int code;
        int id;
    } exp_t;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   rv  [2];
    logic [4*N-1:0] rc  [2];
    logic [N-1:0]   rr  [2];
    logic [3:0]     oc  [2];
    logic           ov  [2];
    logic [1:0]     gid [2];
    logic           bz  [2];

    int   checks = 0;
    int   fails  = 0;
    int   sel    = 0;
    int   gap    = 4;
    int   ptr    = N - 1;
    int   cd     = 0;
    int   cyc    = 0;
    int   last_hs = -1;
    exp_t q[$];
    int   iss_code[$];
    int   iss_id[$];
    int   iss_cyc[$];
    int   t2_exp[6] = '{1, 7, 11, 1, 7, 11};

    always #5 clock = ~clock;

    cmd_arbiter #(.NUM_REQ(3), .GAP_CYCLES(4), .IDLE_CODE(4'hF)) dut_g4 (
        .clock(clock), .reset(reset), .reqValid(rv[0]), .reqCode(rc[0]), .reqReady(rr[0]),
        .outCode(oc[0]), .outValid(ov[0]), .grantId(gid[0]), .busy(bz[0])
    );

    cmd_arbiter #(.NUM_REQ(3), .GAP_CYCLES(0), .IDLE_CODE(4'hF)) dut_g0 (
        .clock(clock), .reset(reset), .reqValid(rv[1]), .reqCode(rc[1]), .reqReady(rr[1]),
        .outCode(oc[1]), .outValid(ov[1]), .grantId(gid[1]), .busy(bz[1])
    );

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: one accept per idle slot, round-robin from the last winner, busy for 1+gap cycles.
    task automatic eval();
        int w = -1;
        int code;
        if (reset) begin
            check("rst_ready", int'(rr[sel]), 0);
            check("rst_busy", int'(bz[sel]), 0);
            last_hs = -1;
            return;
        end
        check("busy", int'(bz[sel]), int'(cd > 0));
        if (cd == 0) begin
            for (int i = 1; i <= N; i++) begin
                int k;
                k = (ptr + i) % N;
                if (w < 0 && rv[sel][k]) w = k;
            end
        end
        check("ready", int'(rr[sel]), (w >= 0) ? (1 << w) : 0);
        if (w >= 0) begin
            ptr  = w;
            code = int'(rc[sel][4*w +: 4]);
            if (code != 15) begin
                q.push_back('{cyc + 1, code, w});
                cd = gap + 1;
            end
        end else if (cd > 0) begin
            cd--;
        end
        last_hs = w;
    endtask

    task automatic tick();
        #1;
        eval();
        @(negedge clock);
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_code", int'(oc[sel]), 15);
        check("rst_valid", int'(ov[sel]), 0);
        check("rst_busy_now", int'(bz[sel]), 0);
        check("rst_ready_now", int'(rr[sel]), 0);
        check("rst_grant", int'(gid[sel]), 0);
        q.delete();
        iss_code.delete();
        iss_id.delete();
        iss_cyc.delete();
        ptr = N - 1;
        cd = 0;
        last_hs = -1;
        @(negedge clock);
        cyc++;
        reset = 1'b0;
    endtask

    task automatic drop_granted();
        if (last_hs >= 0) rv[sel][last_hs] = 1'b0;
    endtask

    task automatic drain();
        rv[sel] = '0;
        for (int i = 0; i < 30; i++) begin
            if (q.size() > 0 || cd > 0) tick();
        end
        #3;
        check("drained", q.size() + cd, 0);
        @(negedge clock);
        cyc++;
    endtask

    task automatic run_until_issue(input string nm);
        int n = 0;
        do begin
            tick();
            n++;
        end while (cd != gap + 1 && n < 40);
        if (cd != gap + 1) check(nm, 0, 1);
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < N; i++) begin
            if (i == last_hs) begin
                rv[sel][i] = 1'b0;
            end else if (rv[sel][i]) begin
                if ($urandom_range(0, 15) == 0) rv[sel][i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                rc[sel][4*i +: 4] = 4'($urandom_range(0, 15));
                rv[sel][i] = 1'b1;
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the selected DUT issues and checks idle cycles.
    always @(negedge clock) begin
        exp_t e;
        #2;
        if (!reset) begin
            if (ov[sel]) begin
                iss_code.push_back(int'(oc[sel]));
                iss_id.push_back(int'(gid[sel]));
                iss_cyc.push_back(cyc);
                if (q.size() == 0) begin
                    check("unexpected_issue", int'(oc[sel]), -1);
                end else begin
                    e = q.pop_front();
                    check("issue_cycle", cyc, e.cyc);
                    check("issue_code", int'(oc[sel]), e.code);
                    check("issue_grant", int'(gid[sel]), e.id);
                end
            end else begin
                check("idle_code", int'(oc[sel]), 15);
                if (q.size() > 0 && q[0].cyc <= cyc) begin
                    e = q.pop_front();
                    check("missed_issue", -1, e.code);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rv[0] = '0; rv[1] = '0; rc[0] = '0; rc[1] = '0;
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            check("init_code", int'(oc[d]), 15);
            check("init_valid", int'(ov[d]), 0);
            check("init_grant", int'(gid[d]), 0);
            check("init_busy", int'(bz[d]), 0);
            check("init_ready", int'(rr[d]), 0);
        end
        @(negedge clock);
        cyc++;
        reset = 1'b0;

        // Single request, then a follow-up request held through ISSUE and GAP.
        sel = 0; gap = 4;
        rc[0] = 12'h070; rv[0] = 3'b010;
        tick();
        drop_granted();
        rc[0] = 12'h073; rv[0][0] = 1'b1;
        for (int i = 0; i < 12; i++) begin tick(); drop_granted(); end
        drain();
        check("t1_count", iss_code.size(), 2);
        if (iss_code.size() == 2) begin
            check("t1_code", iss_code[0], 7);
            check("t1_id", iss_id[0], 1);
            check("t1_second_code", iss_code[1], 3);
            check("t1_spacing", iss_cyc[1] - iss_cyc[0], 6);
        end

        // Round robin with all requesters held valid.
        do_reset();
        rc[0] = 12'hB71; rv[0] = 3'b111;
        for (int i = 0; i < 34; i++) tick();
        drain();
        check("t2_count", int'(iss_code.size() >= 6), 1);
        for (int i = 0; i < 6 && i < iss_code.size(); i++) check("t2_order", iss_code[i], t2_exp[i]);
        for (int i = 1; i < iss_cyc.size(); i++) check("t2_spacing", iss_cyc[i] - iss_cyc[i-1], 6);

        // Idle code is accepted and dropped, but still advances the pointer.
        do_reset();
        rc[0] = 12'h00F; rv[0] = 3'b001;
        tick();
        drop_granted();
        tick();
        rc[0] = 12'h053; rv[0] = 3'b011;
        for (int i = 0; i < 12; i++) begin tick(); drop_granted(); end
        drain();
        check("t3_count", iss_code.size(), 2);
        if (iss_code.size() == 2) begin
            check("t3_first_id", iss_id[0], 1);
            check("t3_first_code", iss_code[0], 5);
            check("t3_second_id", iss_id[1], 0);
        end

        // Zero gap: back-to-back issue every other cycle.
        sel = 1; gap = 0;
        do_reset();
        rc[1] = 12'hD00; rv[1] = 3'b100;
        for (int i = 0; i < 20; i++) tick();
        drain();
        check("t4_count", int'(iss_code.size() >= 9), 1);
        for (int i = 0; i < iss_code.size(); i++) check("t4_code", iss_code[i], 13);
        for (int i = 1; i < iss_cyc.size(); i++) check("t4_spacing", iss_cyc[i] - iss_cyc[i-1], 2);

        // Reset during ISSUE and during GAP discards the command in flight.
        sel = 0; gap = 4;
        do_reset();
        rc[0] = 12'h432; rv[0] = 3'b111;
        run_until_issue("t5_wait_a");
        run_until_issue("t5_wait_b");
        do_reset();
        run_until_issue("t5_wait_c");
        tick();
        tick();
        check("t5_after_issue_reset", iss_code.size(), 1);
        if (iss_code.size() == 1) check("t5_first_after_reset", iss_code[0], 2);
        do_reset();
        run_until_issue("t5_wait_d");
        tick();
        check("t5_after_gap_reset", iss_code.size(), 1);
        if (iss_code.size() == 1) check("t5_first_after_gap_reset", iss_id[0], 0);
        drain();

        // Withdrawal during GAP: the withdrawn request is never accepted.
        do_reset();
        rc[0] = 12'h096; rv[0] = 3'b001;
        tick();
        drop_granted();
        for (int i = 0; i < 10 && cd != 3; i++) tick();
        rv[0][1] = 1'b1;
        for (int i = 0; i < 10 && cd != 1; i++) tick();
        rv[0][1] = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        drain();
        check("t6_count", iss_code.size(), 1);
        if (iss_code.size() == 1) check("t6_id", iss_id[0], 0);

        // Randomized traffic on both gap settings.
        for (int s = 0; s < 2; s++) begin
            sel = s;
            gap = (s == 0) ? 4 : 0;
            do_reset();
            for (int i = 0; i < 250; i++) begin
                rand_inputs();
                tick();
            end
            drain();
        end

        check("final_queue", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/cmd_arbiter.md
Name: cmd_arbiter

Overview:
- Round-robin arbiter and sequencer between NUM_REQ command sources and the single 4-bit command input of the VGA input decoder. Example sources: keyboard decoder, push-button debouncer, UART command parser.
- Accepts one code per valid/ready handshake and drives it onto outCode for exactly one clock, then holds an idle code for a programmable gap.
- The decoder's increment and toggle commands act once per clock. The one-cycle pulse therefore gives exactly one action per accepted command.

Parameters:
- NUM_REQ, 3, number of requesters; legal range 2..8.
- GAP_CYCLES, 4, idle clocks inserted after each issued command; legal range 0..255.
- IDLE_CODE, 4'hF, code driven when no command is issued. Must be a code the decoder ignores.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- reqValid  input  NUM_REQ  per-requester command valid.
- reqCode  input  4*NUM_REQ  per-requester code; requester i uses bits [4i+3:4i].
- reqReady  output  NUM_REQ  per-requester accept. Combinational and one-hot or zero.
- outCode  output  4  command to the decoder; IDLE_CODE when not issuing.
- outValid  output  1  high in the single cycle a real command is on outCode.
- grantId  output  max(1,clog2(NUM_REQ))  index of the requester whose code is on outCode; valid while outValid=1.
- busy  output  1  high in ISSUE and GAP states.

Behaviour:
- Reset values:
  - state=IDLE, outCode=IDLE_CODE, outValid=0, grantId=0, busy=0, reqReady=0.
  - Priority pointer ptr=NUM_REQ-1, so requester 0 is searched first.
  - Gap counter=0.
- Reset mid-operation: any latched code is discarded and never issued; all outputs take reset values immediately (asynchronous).
- State IDLE:
  - Search reqValid starting at (ptr+1) mod NUM_REQ, wrapping; the first set bit is the winner w.
  - reqReady[w]=1, all others 0. A handshake occurs in this cycle because reqValid[w]=1.
  - On handshake: latch reqCode[w], set ptr=w.
  - If the latched code != IDLE_CODE, go to ISSUE. If it == IDLE_CODE, drop it and stay in IDLE; ptr still updates.
  - No reqValid set: reqReady=0, stay in IDLE.
- State ISSUE (exactly 1 cycle):
  - outCode=latched code, outValid=1, grantId=w, busy=1, reqReady=0.
  - Next state is GAP if GAP_CYCLES>0, else IDLE.
- State GAP:
  - outCode=IDLE_CODE, outValid=0, busy=1, reqReady=0.
  - Counter loads GAP_CYCLES-1 on entry and decrements; at 0, go to IDLE.
  - Exactly GAP_CYCLES cycles are spent in GAP.
- Latency: handshake in cycle N → outCode/outValid registered and valid in cycle N+1.
- Throughput: one command per 2+GAP_CYCLES cycles.
- outCode, outValid, grantId and busy are registered; reqReady is combinational from state, ptr and reqValid.
- Requesters must hold reqValid and reqCode stable until reqReady. Deasserting reqValid before the handshake is legal and simply withdraws the request.
- Simultaneous requests: exactly one is granted per IDLE cycle. Fairness: a continuously valid requester waits at most NUM_REQ-1 grants.
- With a non-power-of-2 NUM_REQ, ptr wraps from NUM_REQ-1 to 0.
- Out-of-range requester bits are not present: only NUM_REQ bits are used.

Test Plan:
1. Single request, defaults: reqValid=3'b010, code 4'h7 at cycle N.
   - Required: reqReady=3'b010 at N; outCode=7, outValid=1, grantId=1 at N+1 only.
   - Then outCode=F for 4 cycles; reqReady stays 0 until IDLE at N+6.
2. Round robin: all three requesters held valid with codes 4'h1/4'h7/4'hB.
   - Required: issue order after reset is 1,7,B,1,7,B.
   - Consecutive outValid pulses are exactly 6 cycles apart.
3. Idle-code drop: requester 0 presents 4'hF alone.
   - Required: handshake occurs, no outValid, busy stays 0, ptr=0.
   - Next request from requester 0 and 1 together grants 1 first.
4. GAP_CYCLES=0 with requester 2 continuously valid with 4'hD.
   - Required: outValid pulses every 2 cycles; outCode alternates D, F.
5. Reset asserted during ISSUE, and again during GAP.
   - Required: outCode=F, outValid=0, busy=0 at once; latched code never issued.
   - After release, requester 0 is granted first if all requesters are valid.
6. Withdrawal: requester 1 raises reqValid during GAP and drops it before IDLE.
   - Required: no handshake and no issue; requester 1 is never granted.
